// File: rtl/salamander_pkg.sv
// Shared definitions for the data-memory block copy/fill engine.
package salamander_pkg;
    localparam int DEF_DATA_SIZE = 8;
    localparam int DEF_ADDR_SIZE = 5;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dma_state_t;
endpackage

// File: rtl/data_mem_dma.sv
// Block copy/fill engine in front of the single-port data memory; the CPU port
// passes through whenever the engine is not busy.
module data_mem_dma
    import salamander_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 mode,
    input  logic [ADDR_SIZE-1:0] src,
    input  logic [ADDR_SIZE-1:0] dst,
    input  logic [ADDR_SIZE:0]   len,
    input  logic [DATA_SIZE-1:0] fill_val,
    output logic                 busy,
    output logic                 done,
    input  logic                 cpu_w,
    input  logic [ADDR_SIZE-1:0] cpu_addr,
    input  logic [DATA_SIZE-1:0] cpu_data_wr,
    output logic [DATA_SIZE-1:0] cpu_data_rd,
    output logic                 mem_w,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0] mem_data_wr,
    input  logic [DATA_SIZE-1:0] mem_data_rd
);
    dma_state_t           state, state_n;
    logic [ADDR_SIZE-1:0] src_ptr, dst_ptr;
    logic [ADDR_SIZE:0]   cnt;
    logic                 mode_r;
    logic [DATA_SIZE-1:0] fill_r, data_r;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            src_ptr <= '0;
            dst_ptr <= '0;
            cnt     <= '0;
            mode_r  <= MODE_COPY;
            fill_r  <= '0;
            data_r  <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (start) begin
                    src_ptr <= src;
                    dst_ptr <= dst;
                    cnt     <= len;
                    mode_r  <= mode;
                    fill_r  <= fill_val;
                end
                READ: begin
                    data_r  <= mem_data_rd;
                    src_ptr <= src_ptr + ADDR_SIZE'(1);
                end
                WRITE: begin
                    dst_ptr <= dst_ptr + ADDR_SIZE'(1);
                    cnt     <= cnt - (ADDR_SIZE+1)'(1);
                end
                default: ;
            endcase
        end
    end

    // Port mux and next-state: passthrough is the default, the engine
    // overrides it only in READ/WRITE so CPU writes are dropped while busy.
    always_comb begin
        state_n     = state;
        busy        = 1'b0;
        done        = 1'b0;
        mem_w       = cpu_w;
        mem_addr    = cpu_addr;
        mem_data_wr = cpu_data_wr;
        case (state)
            IDLE: if (start) begin
                if (len == '0)             state_n = DONE;
                else if (mode == MODE_FILL) state_n = WRITE;
                else                       state_n = READ;
            end
            READ: begin
                busy        = 1'b1;
                mem_w       = 1'b0;
                mem_addr    = src_ptr;
                mem_data_wr = data_r;
                state_n     = WRITE;
            end
            WRITE: begin
                busy        = 1'b1;
                mem_w       = 1'b1;
                mem_addr    = dst_ptr;
                mem_data_wr = (mode_r == MODE_FILL) ? fill_r : data_r;
                if (cnt == (ADDR_SIZE+1)'(1)) state_n = DONE;
                else if (mode_r == MODE_COPY)  state_n = READ;
                else                           state_n = WRITE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign cpu_data_rd = mem_data_rd;
endmodule

// File: tb/tb_data_mem_dma.sv
// Directed bench: data_mem_dma in front of a 32x8 memory initialised to mem[i]=i.
module tb_data_mem_dma;
    logic       clk = 1'b0;
    logic       rstn;
    logic       start, mode;
    logic [4:0] src, dst;
    logic [5:0] len;
    logic [7:0] fill_val;
    logic       busy, done;
    logic       cpu_w;
    logic [4:0] cpu_addr;
    logic [7:0] cpu_data_wr, cpu_data_rd;
    logic       mem_w;
    logic [4:0] mem_addr;
    logic [7:0] mem_data_wr, mem_data_rd;

    logic [7:0] mem [0:31];
    int checks = 0;
    int failures = 0;

    data_mem_dma #(.DATA_SIZE(8), .ADDR_SIZE(5)) dut (
        .clk(clk), .rstn(rstn), .start(start), .mode(mode), .src(src), .dst(dst),
        .len(len), .fill_val(fill_val), .busy(busy), .done(done),
        .cpu_w(cpu_w), .cpu_addr(cpu_addr), .cpu_data_wr(cpu_data_wr),
        .cpu_data_rd(cpu_data_rd), .mem_w(mem_w), .mem_addr(mem_addr),
        .mem_data_wr(mem_data_wr), .mem_data_rd(mem_data_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_w) mem[mem_addr] <= mem_data_wr;
    assign mem_data_rd = mem[mem_addr];

    typedef struct {
        string           name;
        logic            mode;
        logic [4:0]      src, dst;
        logic [5:0]      len;
        logic [7:0]      fill;
        int              busy_cyc;
        int              n_chk;
        logic [3:0][4:0] chk_a;
        logic [3:0][7:0] chk_v;
        logic            all_en;
        logic [7:0]      all_val;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic init_mem();
        for (int i = 0; i < 32; i++) mem[i] = 8'(i);
    endtask

    // Launch one transfer and check busy shape, done timing and the done width.
    task automatic run_xfer(input string name, input logic m, input logic [4:0] s,
                            input logic [4:0] d, input logic [5:0] l,
                            input logic [7:0] f, input int exp_busy);
        int busy_err = 0, rd_err = 0, done_cyc = -1;
        start = 1'b1; mode = m; src = s; dst = d; len = l; fill_val = f;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (busy !== ((cyc <= exp_busy) ? 1'b1 : 1'b0)) busy_err++;
            if (cpu_data_rd !== mem_data_rd) rd_err++;
            if (done === 1'b1) begin
                done_cyc = cyc;
                chk({name, " done_passthrough_addr"}, int'(mem_addr), int'(cpu_addr));
                break;
            end
            tick();
        end
        chk({name, " busy_shape_errs"}, busy_err, 0);
        chk({name, " cpu_rd_errs"}, rd_err, 0);
        chk({name, " done_cycle"}, done_cyc, exp_busy + 1);
        tick();
        chk({name, " done_one_cycle"}, int'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_img [0:31];
        int bad;

        vecs[0] = '{"copy", 1'b0, 5'd2, 5'd20, 6'd4, 8'h00, 8, 4,
                    {5'd23, 5'd22, 5'd21, 5'd20}, {8'd5, 8'd4, 8'd3, 8'd2}, 1'b0, 8'h00};
        vecs[1] = '{"fill_wrap", 1'b1, 5'd0, 5'd30, 6'd4, 8'hA5, 4, 4,
                    {5'd1, 5'd0, 5'd31, 5'd30}, {8'hA5, 8'hA5, 8'hA5, 8'hA5}, 1'b0, 8'h00};
        vecs[2] = '{"len0", 1'b0, 5'd3, 5'd9, 6'd0, 8'h00, 0, 0,
                    '0, '0, 1'b0, 8'h00};
        vecs[3] = '{"overlap", 1'b0, 5'd4, 5'd5, 6'd3, 8'h00, 6, 3,
                    {5'd0, 5'd7, 5'd6, 5'd5}, {8'd0, 8'd4, 8'd4, 8'd4}, 1'b0, 8'h00};
        vecs[4] = '{"fill1", 1'b1, 5'd0, 5'd12, 6'd1, 8'h3C, 1, 1,
                    {5'd0, 5'd0, 5'd0, 5'd12}, {8'd0, 8'd0, 8'd0, 8'h3C}, 1'b0, 8'h00};
        vecs[5] = '{"fill_all", 1'b1, 5'd0, 5'd7, 6'd32, 8'h11, 32, 0,
                    '0, '0, 1'b1, 8'h11};
        vecs[6] = '{"copy_wrap", 1'b0, 5'd30, 5'd1, 6'd3, 8'h00, 6, 3,
                    {5'd0, 5'd3, 5'd2, 5'd1}, {8'd0, 8'd0, 8'd31, 8'd30}, 1'b0, 8'h00};

        rstn = 1'b0; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0;
        fill_val = '0; cpu_w = 1'b0; cpu_addr = 5'd7; cpu_data_wr = 8'h00;
        init_mem();
        #12;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset passthrough addr", int'(mem_addr), 7);
        chk("reset passthrough w", int'(mem_w), 0);
        chk("reset cpu_rd", int'(cpu_data_rd), 7);
        tick();
        rstn = 1'b1;
        tick();

        // idle passthrough write
        cpu_w = 1'b1; cpu_addr = 5'd3; cpu_data_wr = 8'h5A;
        #1 chk("idle passthrough data", int'(mem_data_wr), 'h5A);
        tick();
        cpu_w = 1'b0;
        chk("idle passthrough write", int'(mem[3]), 'h5A);

        foreach (vecs[v]) begin
            init_mem();
            cpu_addr = 5'd0;
            run_xfer(vecs[v].name, vecs[v].mode, vecs[v].src, vecs[v].dst,
                     vecs[v].len, vecs[v].fill, vecs[v].busy_cyc);
            for (int i = 0; i < 32; i++)
                exp_img[i] = vecs[v].all_en ? vecs[v].all_val : 8'(i);
            for (int k = 0; k < vecs[v].n_chk; k++)
                exp_img[vecs[v].chk_a[k]] = vecs[v].chk_v[k];
            bad = 0;
            for (int i = 0; i < 32; i++) if (mem[i] !== exp_img[i]) bad++;
            chk({vecs[v].name, " mem_bad_words"}, bad, 0);
        end

        // CPU write blocked while busy; start pulses in busy and DONE ignored
        init_mem();
        start = 1'b1; mode = 1'b1; dst = 5'd0; len = 6'd2; fill_val = 8'h77;
        tick();
        cpu_w = 1'b1; cpu_addr = 5'd10; cpu_data_wr = 8'hFF;
        start = 1'b1; mode = 1'b0; src = 5'd20; dst = 5'd25; len = 6'd5;
        chk("blk busy c1", int'(busy), 1);
        chk("blk mem_addr c1", int'(mem_addr), 0);
        chk("blk cpu_rd c1", int'(cpu_data_rd), 0);
        tick();
        start = 1'b0;
        chk("blk busy c2", int'(busy), 1);
        chk("blk mem10 c2", int'(mem[10]), 10);
        tick();
        chk("blk done c3", int'(done), 1);
        chk("blk mem10 in done", int'(mem[10]), 10);
        chk("blk done passthrough w", int'(mem_w), 1);
        start = 1'b1; mode = 1'b1; dst = 5'd2; len = 6'd3; fill_val = 8'hEE;
        tick();
        start = 1'b0;
        chk("blk mem10 after", int'(mem[10]), 'hFF);
        chk("blk busy after done", int'(busy), 0);
        chk("blk mem0", int'(mem[0]), 'h77);
        chk("blk mem1", int'(mem[1]), 'h77);
        chk("blk mem2", int'(mem[2]), 2);
        chk("blk mem25", int'(mem[25]), 25);
        tick();
        chk("blk idle busy", int'(busy), 0);
        chk("blk idle done", int'(done), 0);
        cpu_w = 1'b0;

        // async reset mid-copy
        init_mem();
        cpu_addr = 5'd0;
        start = 1'b1; mode = 1'b0; src = 5'd0; dst = 5'd16; len = 6'd8;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("rst pre busy", int'(busy), 1);
        rstn = 1'b0;
        #1;
        chk("rst busy immediate", int'(busy), 0);
        chk("rst done immediate", int'(done), 0);
        tick();
        chk("rst done held", int'(done), 0);
        chk("rst w held", int'(mem_w), 0);
        rstn = 1'b1;
        tick();
        chk("rst no done after release", int'(done), 0);
        chk("rst mem16", int'(mem[16]), 0);
        chk("rst mem17", int'(mem[17]), 1);
        chk("rst mem18", int'(mem[18]), 18);
        chk("rst mem19", int'(mem[19]), 19);
        run_xfer("post_rst", 1'b0, 5'd8, 5'd16, 6'd2, 8'h00, 4);
        chk("post_rst mem16", int'(mem[16]), 8);
        chk("post_rst mem17", int'(mem[17]), 9);
        chk("post_rst mem18", int'(mem[18]), 18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
